div_share_ctrl: RTL and testbench
=================================

# div_share_ctrl

Round-robin controller that shares one sequential signed divider among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and screens out divide-by-zero without using the divider. It sequences the divider through a start/done interface, guards each operation with a timeout, and returns quotient, remainder, error flag and requester ID on a single response port with backpressure. It sits between the arithmetic clients and the shared divider core.

## Interface
- N, 5: operand/result width, two's complement.
- NREQ, 4: number of requesters (2..8).
- TIMEOUT, 16: maximum cycles to wait for div_done after div_start.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  bit i: requester i holds a valid operand pair.
- req_ready  out  NREQ  bit i: requester i accepted this cycle (one-hot or zero).
- req_a  in  NREQ*N  dividend of requester i at bits [i*N +: N].
- req_b  in  NREQ*N  divisor of requester i at bits [i*N +: N].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  3  index of requester that owns the response.
- rsp_q  out  N  signed quotient.
- rsp_r  out  N  signed remainder.
- rsp_err  out  1  divide-by-zero or timeout.
- rsp_tmo  out  1  error cause was timeout (valid with rsp_err).
- div_start  out  1  one-cycle start pulse to divider.
- div_a  out  N  dividend to divider, held from ISSUE until the next accept.
- div_b  out  N  divisor to divider, held from ISSUE until the next accept.
- div_done  in  1  divider result valid (single-cycle pulse).
- div_q  in  N  divider quotient.
- div_r  in  N  divider remainder.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbiter selects g = first i with req_valid[i], searching from ptr+1 modulo NREQ.
  - req_ready[g]=1 combinationally; all other bits are 0.
  - On that edge: latch a, b and id=g; set ptr=g.
  - If latched b==0: go to RESP with err=1, tmo=0, q=r=0. The divider is not started.
  - Otherwise go to ISSUE.
  - With no req_valid bit set: stay in IDLE.
- ISSUE:
  - div_start=1 for exactly one cycle; div_a/div_b carry the latched operands.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On div_done: capture div_q/div_r, err=0, go to RESP.
  - If the counter reaches TIMEOUT without div_done: err=1, tmo=1, q=r=0, go to RESP.
  - div_done in the same cycle the counter reaches TIMEOUT: div_done wins.
- RESP:
  - rsp_valid=1; rsp_* are held stable until rsp_valid&&rsp_ready.
  - On that handshake: go to IDLE.
- div_done outside WAIT is ignored; a late done after a timeout does not corrupt a later response.
- req_ready is 0 in every state except IDLE. Requesters hold req_a/req_b stable while req_valid=1.
- Divider results are passed through unmodified; the controller performs no sign correction. Overflow cases such as -16/-1 at N=5 are the divider's responsibility.
- Reset:
  - State=IDLE; ptr=NREQ-1, so requester 0 has first priority.
  - All outputs 0: rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, rsp_tmo, div_start, div_a, div_b; req_ready=0 during the reset cycle.
  - Reset in any state aborts the operation with no response, and the next accept restarts the divider cleanly.

## Timing
- Accept on edge T → div_start high in cycle T+1 → WAIT from T+2.
- div_done sampled in cycle D → rsp_valid high from D+1.
- Divide-by-zero: rsp_valid high from T+1; div_start never asserted.
- Timeout: rsp_valid high TIMEOUT+1 cycles after div_start.
- The rsp handshake edge returns the controller to IDLE. The earliest next accept is the following cycle, so there is at least one bubble between operations.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.
- No requester waits more than NREQ-1 operations.

## Test plan
- Simple divide:
  - Stimulus: req0 a=7 b=2; divider model returns 3/1 after 6 cycles.
  - Required: rsp_id=0, q=3, r=1, err=0; div_start exactly one pulse at T+1.
- Signed pass-through:
  - Stimulus: req2 a=-7 b=2; model returns q=-3 r=-1.
  - Required: rsp_id=2, q=-3 (5'b11101), r=-1 (5'b11111), err=0.
- Divide by zero:
  - Stimulus: req1 a=5 b=0.
  - Required: rsp_valid at T+1, err=1, tmo=0, q=r=0, div_start never high.
- Round-robin:
  - Stimulus: all four requesters held valid; rsp_ready=1.
  - Required: accept order 0,1,2,3,0,1; req_ready one-hot each accept.
- Timeout and backpressure:
  - Stimulus: model never asserts done; rsp_ready low for 5 cycles.
  - Required: rsp_valid 17 cycles after div_start with err=1, tmo=1, outputs stable until rsp_ready. A subsequent late div_done in IDLE is ignored.
- Reset mid-operation:
  - Stimulus: assert rst in WAIT cycle 3.
  - Required: next cycle all outputs 0, state IDLE, no response. The next request gets requester 0 priority and completes correctly.

Source files
------------

// File: rtl/div_share_ctrl.sv
// Round-robin front end that shares one sequential signed divider among NREQ requesters.
// Screens out divide-by-zero locally, bounds each divide with a timeout, and holds the response until it is consumed.
module div_share_ctrl #(
  parameter int N       = 5,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_id,
  output logic [N-1:0]      rsp_q,
  output logic [N-1:0]      rsp_r,
  output logic              rsp_err,
  output logic              rsp_tmo,
  output logic              div_start,
  output logic [N-1:0]      div_a,
  output logic [N-1:0]      div_b,
  input  logic              div_done,
  input  logic [N-1:0]      div_q,
  input  logic [N-1:0]      div_r
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state, state_nx;
  logic [2:0]     ptr;
  logic [2:0]     id_q;
  logic [N-1:0]   a_q, b_q, q_q, r_q;
  logic           err_q, tmo_q;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_inc;
  logic           tmo_hit;

  int             sel;
  logic           gnt_any;
  logic [2:0]     gnt_id;
  logic [N-1:0]   a_sel, b_sel;

  // Walk from ptr+NREQ down to ptr+1 so the nearest requester after ptr wins.
  always_comb begin
    sel     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      sel = (int'(ptr) + k) % NREQ;
      if (req_valid[sel[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = sel[2:0];
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == 3'(i)) begin
        a_sel = req_a[i*N +: N];
        b_sel = req_b[i*N +: N];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && gnt_any) req_ready[gnt_id[IW-1:0]] = 1'b1;
  end

  assign cnt_inc = cnt + 1'b1;
  assign tmo_hit = (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_any) state_nx = (b_sel == '0) ? RESP : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (div_done || tmo_hit) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'(NREQ - 1);
      id_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      err_q <= 1'b0;
      tmo_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (gnt_any) begin
          a_q   <= a_sel;
          b_q   <= b_sel;
          id_q  <= gnt_id;
          ptr   <= gnt_id;
          q_q   <= '0;
          r_q   <= '0;
          err_q <= (b_sel == '0);
          tmo_q <= 1'b0;
        end
        ISSUE: cnt <= '0;
        // A done arriving on the timeout cycle still counts as a real result.
        WAIT: begin
          cnt <= cnt_inc;
          if (div_done) begin
            q_q   <= div_q;
            r_q   <= div_r;
            err_q <= 1'b0;
            tmo_q <= 1'b0;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            tmo_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign div_start = (state == ISSUE);
  assign rsp_id    = id_q;
  assign rsp_q     = q_q;
  assign rsp_r     = r_q;
  assign rsp_err   = err_q;
  assign rsp_tmo   = tmo_q;
  assign div_a     = a_q;
  assign div_b     = b_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a simple latency-programmable divider model.
module tb_div_share_ctrl;
  localparam int N = 5;
  localparam int NREQ = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_id;
  logic [N-1:0]      rsp_q, rsp_r;
  logic              rsp_err, rsp_tmo;
  logic              div_start;
  logic [N-1:0]      div_a, div_b;
  logic              div_done;
  logic [N-1:0]      div_q, div_r;

  div_share_ctrl #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  always #5 clk = ~clk;

  // Divider model: done pulses m_lat cycles after the start cycle.
  logic [N-1:0] m_q, m_r;
  int           m_lat;
  logic         m_en;
  logic         late_done;
  int           mcnt;

  always @(posedge clk) begin
    if (rst) mcnt <= 0;
    else if (div_start && m_en) mcnt <= m_lat;
    else if (mcnt != 0) mcnt <= mcnt - 1;
  end

  assign div_done = (mcnt == 1) || late_done;
  assign div_q = m_q;
  assign div_r = m_r;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  typedef struct {
    int          id;
    logic [N-1:0] a, b, mq, mr;
    int          lat;
    logic        en;
    logic [N-1:0] eq, er;
    logic        eerr, etmo;
    int          ek, es, hold;
  } vec_t;

  task automatic run_op(input vec_t v, input logic [NREQ-1:0] others, input string tag);
    int rk, starts, w;
    rk = 0; starts = 0;
    m_q = v.mq; m_r = v.mr; m_lat = v.lat; m_en = v.en;
    req_a[v.id*N +: N] = v.a;
    req_b[v.id*N +: N] = v.b;
    req_valid = others | oh(v.id);
    #1;
    for (w = 0; w < 20 && req_ready == '0; w++) @(negedge clk);
    chk({tag, "_grant"}, int'(req_ready), int'(oh(v.id)));
    @(posedge clk);
    #1 req_valid = others;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (div_start) starts++;
      if (rsp_valid) begin
        rk = k;
        break;
      end
    end
    chk({tag, "_latency"}, rk, v.ek);
    chk({tag, "_starts"}, starts, v.es);
    chk({tag, "_id"}, int'(rsp_id), v.id);
    chk({tag, "_q"}, int'(rsp_q), int'(v.eq));
    chk({tag, "_r"}, int'(rsp_r), int'(v.er));
    chk({tag, "_err"}, int'(rsp_err), int'(v.eerr));
    if (v.eerr) chk({tag, "_tmo"}, int'(rsp_tmo), int'(v.etmo));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, int'(rsp_valid), 1);
      chk({tag, "_hold_q"}, int'({rsp_q, rsp_r, rsp_err, rsp_tmo}),
          int'({v.eq, v.er, v.eerr, v.etmo}));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_released"}, int'(rsp_valid), 0);
  endtask

  vec_t vt[6];
  vec_t vtmo;
  int   rr_seq[6];

  initial begin
    rst = 1'b1; rsp_ready = 1'b0; late_done = 1'b0;
    m_q = '0; m_r = '0; m_lat = 1; m_en = 1'b1;
    req_a = '0; req_b = {NREQ{5'd1}}; req_valid = '1;
    // Operands: id, a, b, model q, model r, lat, en, exp q, exp r, err, tmo, rsp cycle, starts, hold
    vt[0] = '{0, 5'd7,  5'd2,  5'd3,  5'd1,  6,  1'b1, 5'd3,  5'd1,  1'b0, 1'b0, 8,  1, 0};
    vt[1] = '{2, 5'h19, 5'd2,  5'h1d, 5'h1f, 3,  1'b1, 5'h1d, 5'h1f, 1'b0, 1'b0, 5,  1, 0};
    vt[2] = '{1, 5'd5,  5'd0,  5'h0a, 5'h05, 2,  1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 1,  0, 0};
    vt[3] = '{3, 5'h10, 5'h1f, 5'h10, 5'd0,  1,  1'b1, 5'h10, 5'd0,  1'b0, 1'b0, 3,  1, 0};
    vt[4] = '{0, 5'h1b, 5'd0,  5'h07, 5'h07, 2,  1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 1,  0, 2};
    vt[5] = '{1, 5'd9,  5'd4,  5'd2,  5'd1,  16, 1'b1, 5'd2,  5'd1,  1'b0, 1'b0, 18, 1, 0};
    vtmo  = '{2, 5'd9,  5'd3,  5'h0f, 5'h0f, 1,  1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 18, 1, 5};
    rr_seq[0] = 0; rr_seq[1] = 1; rr_seq[2] = 2; rr_seq[3] = 3; rr_seq[4] = 0; rr_seq[5] = 1;

    repeat (2) @(negedge clk);
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_rsp", int'({rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, rsp_tmo}), 0);
    chk("reset_div", int'({div_start, div_a, div_b}), 0);
    rst = 1'b0;

    // Round robin with every requester continuously valid.
    begin
      int n;
      n = 0;
      m_q = 5'd2; m_r = 5'd0; m_lat = 2; m_en = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*N +: N] = 5'd6;
        req_b[i*N +: N] = 5'd3;
      end
      rsp_ready = 1'b1;
      req_valid = '1;
      #1;
      for (int c = 0; c < 200 && n < 6; c++) begin
        if (req_ready != '0) begin
          chk($sformatf("rr_grant%0d", n), int'(req_ready), int'(oh(rr_seq[n])));
          n++;
        end
        if (n < 6) @(negedge clk);
      end
      chk("rr_count", n, 6);
      @(posedge clk);
      #1 req_valid = '0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (rsp_valid) break;
      end
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("rr_drained", int'(rsp_valid), 0);
    end

    for (int i = 0; i < 6; i++) run_op(vt[i], '0, $sformatf("vec%0d", i));

    // Timeout with backpressure, then a stray done while idle.
    run_op(vtmo, '0, "timeout");
    late_done = 1'b1;
    @(negedge clk);
    late_done = 1'b0;
    chk("late_done_rsp", int'(rsp_valid), 0);
    @(negedge clk);
    chk("late_done_quiet", int'({rsp_valid, div_start}), 0);
    run_op(vt[0], '0, "after_tmo");

    // Reset during the third WAIT cycle.
    m_en = 1'b0;
    req_a[3*N +: N] = 5'd7;
    req_b[3*N +: N] = 5'd3;
    req_valid = oh(3);
    #1;
    chk("rst_pre_grant", int'(req_ready), int'(oh(3)));
    @(posedge clk);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp", int'({rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, rsp_tmo}), 0);
    chk("rst_div", int'({div_start, div_a, div_b}), 0);
    rst = 1'b0;
    run_op(vt[0], oh(3), "post_rst");
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end
endmodule
